calendar: RTL and testbench

CALENDAR -- requirements
Module: calendar

---
 rtl/calendar.sv | 169 ++++++++++++++++
 tb/tb_calendar.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/calendar.sv
// ============================================================================
// Module   : calendar
// Brief    : Day/month/year counter advanced by the 23->0 hour rollover, with
//            a sanitised asynchronous date load and BCD digit outputs.
//            Macro GREGORIAN_LEAP_EN selects the full Gregorian leap rule.
// Revision : 1.0
// ============================================================================
`default_nettype none

module calendar (
    input  logic        clk_1hz,
    input  logic        date_ow,
    input  logic [20:0] date_in,
    input  logic [4:0]  hour_in,
    output logic        new_day,
    output logic        leap,
    output logic [3:0]  day_1s,
    output logic [3:0]  day_10s,
    output logic [3:0]  mon_1s,
    output logic [3:0]  mon_10s,
    output logic [3:0]  yr_1s,
    output logic [3:0]  yr_10s,
    output logic [3:0]  yr_100s,
    output logic [3:0]  yr_1000s
);

    localparam logic [4:0] C_LAST_HOUR = 5'd23;

    logic [4:0]  r_day;
    logic [3:0]  r_month;
    logic [11:0] r_year;
    logic [4:0]  r_prev_hour;
    logic        r_new_day;

    function automatic logic is_leap(input logic [11:0] y);
`ifdef GREGORIAN_LEAP_EN
        return (y[1:0] == 2'b00) &&
               (((y % 12'd100) != 12'd0) || ((y % 12'd400) == 12'd0));
`else
        return (y[1:0] == 2'b00);
`endif
    endfunction

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
        logic [4:0] len;
        case (m)
            4'd2:                     len = lp ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:  len = 5'd30;
            default:                  len = 5'd31;
        endcase
        return len;
    endfunction

    // Shift-and-add-3 conversion; small fixed widths keep it cheap.
    function automatic logic [15:0] bcd12(input logic [11:0] bin);
        logic [15:0] bcd;
        bcd = 16'd0;
        for (int i = 11; i >= 0; i--) begin
            for (int k = 0; k < 4; k++) begin
                if (bcd[4*k +: 4] > 4'd4)
                    bcd[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
            bcd = {bcd[14:0], bin[i]};
        end
        return bcd;
    endfunction

    function automatic logic [7:0] bcd5(input logic [4:0] bin);
        logic [7:0] bcd;
        bcd = 8'd0;
        for (int i = 4; i >= 0; i--) begin
            for (int k = 0; k < 2; k++) begin
                if (bcd[4*k +: 4] > 4'd4)
                    bcd[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
            bcd = {bcd[6:0], bin[i]};
        end
        return bcd;
    endfunction

    // Load-path sanitising
    logic [11:0] w_ld_year;
    logic [3:0]  w_ld_month;
    logic [4:0]  w_ld_day;
    logic [4:0]  w_ld_len;

    always_comb begin
        w_ld_year  = date_in[20:9];
        w_ld_month = date_in[8:5];
        if ((w_ld_month == 4'd0) || (w_ld_month > 4'd12))
            w_ld_month = 4'd1;
        w_ld_len = month_len(w_ld_month, is_leap(w_ld_year));
        w_ld_day = date_in[4:0];
        if (w_ld_day == 5'd0)
            w_ld_day = 5'd1;
        else if (w_ld_day > w_ld_len)
            w_ld_day = w_ld_len;
    end

    // Advance path
    logic        w_rollover;
    logic        w_leap;
    logic [4:0]  w_cur_len;
    logic [4:0]  w_nxt_day;
    logic [3:0]  w_nxt_month;
    logic [11:0] w_nxt_year;

    assign w_leap     = is_leap(r_year);
    assign w_cur_len  = month_len(r_month, w_leap);
    // Requiring hour_in == 0 also rejects out-of-range hours.
    assign w_rollover = (r_prev_hour == C_LAST_HOUR) && (hour_in == 5'd0);

    always_comb begin
        w_nxt_day   = r_day;
        w_nxt_month = r_month;
        w_nxt_year  = r_year;
        if (r_day < w_cur_len) begin
            w_nxt_day = r_day + 5'd1;
        end else begin
            w_nxt_day = 5'd1;
            if (r_month == 4'd12) begin
                w_nxt_month = 4'd1;
                w_nxt_year  = r_year + 12'd1;
            end else begin
                w_nxt_month = r_month + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_1hz or posedge date_ow) begin
        if (date_ow) begin
            r_day       <= w_ld_day;
            r_month     <= w_ld_month;
            r_year      <= w_ld_year;
            r_prev_hour <= 5'd0;
            r_new_day   <= 1'b0;
        end else begin
            r_prev_hour <= hour_in;
            r_new_day   <= w_rollover;
            if (w_rollover) begin
                r_day   <= w_nxt_day;
                r_month <= w_nxt_month;
                r_year  <= w_nxt_year;
            end
        end
    end

    logic [7:0]  w_day_bcd;
    logic [7:0]  w_mon_bcd;
    logic [15:0] w_yr_bcd;

    assign w_day_bcd = bcd5(r_day);
    assign w_mon_bcd = bcd5({1'b0, r_month});
    assign w_yr_bcd  = bcd12(r_year);

    assign new_day  = r_new_day;
    assign leap     = w_leap;
    assign day_1s   = w_day_bcd[3:0];
    assign day_10s  = w_day_bcd[7:4];
    assign mon_1s   = w_mon_bcd[3:0];
    assign mon_10s  = w_mon_bcd[7:4];
    assign yr_1s    = w_yr_bcd[3:0];
    assign yr_10s   = w_yr_bcd[7:4];
    assign yr_100s  = w_yr_bcd[11:8];
    assign yr_1000s = w_yr_bcd[15:12];

endmodule

`default_nettype wire

// File: tb/tb_calendar.sv
// ============================================================================
// Module   : tb_calendar
// Brief    : Directed self-checking bench for calendar; dates compared as
//            packed BCD words 0xYYYYMMDD.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_calendar;

    logic        clk_1hz = 1'b0;
    logic        date_ow = 1'b0;
    logic [20:0] date_in = '0;
    logic [4:0]  hour_in = '0;
    logic        new_day, leap;
    logic [3:0]  day_1s, day_10s, mon_1s, mon_10s;
    logic [3:0]  yr_1s, yr_10s, yr_100s, yr_1000s;

    int vectors = 0;
    int errors  = 0;

    calendar dut (
        .clk_1hz (clk_1hz),
        .date_ow (date_ow),
        .date_in (date_in),
        .hour_in (hour_in),
        .new_day (new_day),
        .leap    (leap),
        .day_1s  (day_1s),
        .day_10s (day_10s),
        .mon_1s  (mon_1s),
        .mon_10s (mon_10s),
        .yr_1s   (yr_1s),
        .yr_10s  (yr_10s),
        .yr_100s (yr_100s),
        .yr_1000s(yr_1000s)
    );

    always #5 clk_1hz = ~clk_1hz;

    logic [31:0] date_bcd;
    assign date_bcd = {yr_1000s, yr_100s, yr_10s, yr_1s,
                       mon_10s, mon_1s, day_10s, day_1s};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic load(input int y, input int m, input int d);
        date_in = {y[11:0], m[3:0], d[4:0]};
        hour_in = 5'd0;
        date_ow = 1'b1;
        @(posedge clk_1hz);
        #1;
        date_ow = 1'b0;
    endtask

    task automatic tick(input int h);
        hour_in = h[4:0];
        @(posedge clk_1hz);
        #1;
    endtask

    logic [31:0] exp_2100;
    logic        exp_2100_leap;

    initial begin
`ifdef GREGORIAN_LEAP_EN
        exp_2100      = 32'h2100_0301;
        exp_2100_leap = 1'b0;
`else
        exp_2100      = 32'h2100_0229;
        exp_2100_leap = 1'b1;
`endif
        #2;

        // Leap February
        load(2024, 2, 28);
        check("load_2024_0228", date_bcd, 32'h2024_0228);
        check("leap_2024", {31'd0, leap}, 32'd1);
        check("new_day_after_load", {31'd0, new_day}, 32'd0);
        tick(23);
        check("no_pulse_at_23", {31'd0, new_day}, 32'd0);
        tick(0);
        check("adv_2024_0229", date_bcd, 32'h2024_0229);
        check("pulse_on_rollover", {31'd0, new_day}, 32'd1);
        tick(0);
        check("pulse_one_cycle", {31'd0, new_day}, 32'd0);
        check("hold_2024_0229", date_bcd, 32'h2024_0229);

        // Year rollover
        load(2023, 12, 31);
        check("leap_2023", {31'd0, leap}, 32'd0);
        tick(23);
        tick(0);
        check("adv_2024_0101", date_bcd, 32'h2024_0101);
        check("leap_after_ny", {31'd0, leap}, 32'd1);

        // Century year
        load(2100, 2, 28);
        check("leap_2100", {31'd0, leap}, {31'd0, exp_2100_leap});
        tick(23);
        tick(0);
        check("adv_2100_0228", date_bcd, exp_2100);

        // Load sanitising
        load(2023, 13, 31);
        check("san_month13", date_bcd, 32'h2023_0131);
        load(2023, 4, 31);
        check("san_apr31", date_bcd, 32'h2023_0430);
        load(2023, 0, 0);
        check("san_zero", date_bcd, 32'h2023_0101);
        load(2023, 2, 30);
        check("san_feb30", date_bcd, 32'h2023_0228);

        // Month ends
        tick(23);
        tick(0);
        check("adv_2023_0301", date_bcd, 32'h2023_0301);
        load(2023, 4, 30);
        tick(23);
        tick(0);
        check("adv_2023_0501", date_bcd, 32'h2023_0501);
        load(2023, 5, 15);
        tick(23);
        tick(0);
        check("adv_2023_0516", date_bcd, 32'h2023_0516);

        // Year wrap
        load(4095, 12, 31);
        tick(23);
        tick(0);
        check("wrap_0000_0101", date_bcd, 32'h0000_0101);
        check("leap_year0", {31'd0, leap}, 32'd1);

        // Non-rollover hour sequences, including out-of-range hours
        load(2023, 6, 10);
        tick(22);
        check("seq_22", {31'd0, new_day}, 32'd0);
        tick(0);
        check("seq_22_0", {31'd0, new_day}, 32'd0);
        tick(23);
        tick(5);
        check("seq_23_5", {31'd0, new_day}, 32'd0);
        tick(0);
        check("seq_5_0", {31'd0, new_day}, 32'd0);
        tick(23);
        tick(31);
        tick(0);
        check("seq_23_31_0", {31'd0, new_day}, 32'd0);
        check("seq_no_adv", date_bcd, 32'h2023_0610);

        // Load wins over a coincident rollover
        load(2023, 3, 10);
        tick(23);
        date_in = {12'd2025, 4'd6, 5'd15};
        hour_in = 5'd0;
        date_ow = 1'b1;
        @(posedge clk_1hz);
        #1;
        check("ow_wins_date", date_bcd, 32'h2025_0615);
        check("ow_wins_pulse", {31'd0, new_day}, 32'd0);
        date_ow = 1'b0;
        tick(0);
        check("ow_after_date", date_bcd, 32'h2025_0615);
        check("ow_after_pulse", {31'd0, new_day}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
